mem_arbiter: RTL and testbench

- Shares the single unified instruction/data memory port between two requesters: the multicycle RISC-V core (port C) and a program loader/debug master (port L).
- Sits between the processor/loader and `mem`. It drives `mem`'s address, write-enable and write-data inputs and returns read data to the active requester.
- Uses round-robin ownership with an optional hold limit. The core stalls on `c_gnt` low.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/arb_port_resp.sv | 37 +++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_C = 2'd1,
      OWN_L = 2'd2
   } arb_state_t;

   typedef enum logic {
      PORT_C = 1'b0,
      PORT_L = 1'b1
   } port_t;

   localparam int unsigned DEFAULT_MAX_HOLD = 16;

   // Width of the hold counter: it only ever has to reach MAX_HOLD-1.
   function automatic int unsigned hold_width(input int unsigned max_hold);
      return (max_hold < 2) ? 1 : $clog2(max_hold);
   endfunction

endpackage

// File: rtl/arb_port_resp.sv
// Per-requester response path: captures read data on a granted read and
// produces the one-cycle rvalid pulse that follows it.
module arb_port_resp #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_gnt,
   input  logic              i_we,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_rvalid
);

   logic              w_rd;
   logic              r_rvalid;
   logic [DATA_W-1:0] r_rdata;

   assign w_rd = i_gnt & ~i_we;

   // Register read data on granted reads; rdata holds between reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= w_rd;
         if (w_rd) begin
            r_rdata <= i_mem_rdata;
         end
      end
   end

   assign o_rdata  = r_rdata;
   assign o_rvalid = r_rvalid;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the core (C) and the
// program loader (L), with an optional limit on back-to-back grants.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int          ADDR_W   = 32,
   parameter int          DATA_W   = 32,
   parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_adr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic [DATA_W-1:0] c_rdata,
   output logic              c_rvalid,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_adr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_gnt,
   output logic [DATA_W-1:0] l_rdata,
   output logic              l_rvalid,
   output logic [ADDR_W-1:0] mem_adr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned         HOLD_W    = hold_width(MAX_HOLD);
   localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);
   localparam logic [HOLD_W-1:0]   HOLD_SAT  = {HOLD_W{1'b1}};

   arb_state_t        r_state, w_state_next;
   port_t             r_last, w_last_next;
   logic [HOLD_W-1:0] r_hold_cnt, w_hold_next;
   logic              w_c_gnt, w_l_gnt;

   assign w_c_gnt = (r_state == OWN_C) & c_req;
   assign w_l_gnt = (r_state == OWN_L) & l_req;
   assign c_gnt   = w_c_gnt;
   assign l_gnt   = w_l_gnt;

   // Ownership state, tie-break memory and hold counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_last     <= PORT_L;
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_last     <= w_last_next;
         r_hold_cnt <= w_hold_next;
      end
   end

   // Next owner: yield on idle owner, forced yield when the hold limit is hit.
   always_comb begin
      w_state_next = r_state;
      w_last_next  = r_last;
      w_hold_next  = r_hold_cnt;
      case (r_state)
         IDLE: begin
            if (c_req && l_req) begin
               w_state_next = (r_last == PORT_L) ? OWN_C : OWN_L;
            end else if (c_req) begin
               w_state_next = OWN_C;
            end else if (l_req) begin
               w_state_next = OWN_L;
            end
         end
         OWN_C: begin
            if (!c_req) begin
               w_state_next = l_req ? OWN_L : IDLE;
            end else if (l_req) begin
               if ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST)) begin
                  w_state_next = OWN_L;
               end else if (r_hold_cnt != HOLD_SAT) begin
                  w_hold_next = r_hold_cnt + HOLD_ONE;
               end
            end
         end
         OWN_L: begin
            if (!l_req) begin
               w_state_next = c_req ? OWN_C : IDLE;
            end else if (c_req) begin
               if ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST)) begin
                  w_state_next = OWN_C;
               end else if (r_hold_cnt != HOLD_SAT) begin
                  w_hold_next = r_hold_cnt + HOLD_ONE;
               end
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
      // A fresh owner restarts its hold count and becomes the tie loser.
      if ((w_state_next == OWN_C) && (r_state != OWN_C)) begin
         w_last_next = PORT_C;
         w_hold_next = '0;
      end else if ((w_state_next == OWN_L) && (r_state != OWN_L)) begin
         w_last_next = PORT_L;
         w_hold_next = '0;
      end
   end

   // Memory port mux: only a granted requester reaches the memory.
   always_comb begin
      mem_adr   = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (w_c_gnt) begin
         mem_adr   = c_adr;
         mem_we    = c_we;
         mem_wdata = c_wdata;
      end else if (w_l_gnt) begin
         mem_adr   = l_adr;
         mem_we    = l_we;
         mem_wdata = l_wdata;
      end
   end

   arb_port_resp #(.DATA_W(DATA_W)) u_resp_c (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_gnt       (w_c_gnt),
      .i_we        (c_we),
      .i_mem_rdata (mem_rdata),
      .o_rdata     (c_rdata),
      .o_rvalid    (c_rvalid)
   );

   arb_port_resp #(.DATA_W(DATA_W)) u_resp_l (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_gnt       (w_l_gnt),
      .i_we        (l_we),
      .i_mem_rdata (mem_rdata),
      .o_rdata     (l_rdata),
      .o_rvalid    (l_rvalid)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (hold limit 4 and unlimited) share the
// same stimulus; a behavioural ownership/memory model predicts every output.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
   logic [31:0] c_adr = '0, c_wdata = '0, l_adr = '0, l_wdata = '0;

   logic        o_c_gnt [2];
   logic        o_l_gnt [2];
   logic        o_c_rvalid [2];
   logic        o_l_rvalid [2];
   logic [31:0] o_c_rdata [2];
   logic [31:0] o_l_rdata [2];
   logic [31:0] o_mem_adr [2];
   logic        o_mem_we [2];
   logic [31:0] o_mem_wdata [2];
   logic [31:0] mem_rdata [2];

   logic [31:0] env_mem [2][64];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) u_dut_h4 (
      .clk(clk), .reset_n(reset_n),
      .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wdata(c_wdata),
      .c_gnt(o_c_gnt[0]), .c_rdata(o_c_rdata[0]), .c_rvalid(o_c_rvalid[0]),
      .l_req(l_req), .l_we(l_we), .l_adr(l_adr), .l_wdata(l_wdata),
      .l_gnt(o_l_gnt[0]), .l_rdata(o_l_rdata[0]), .l_rvalid(o_l_rvalid[0]),
      .mem_adr(o_mem_adr[0]), .mem_we(o_mem_we[0]), .mem_wdata(o_mem_wdata[0]),
      .mem_rdata(mem_rdata[0])
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(0)) u_dut_h0 (
      .clk(clk), .reset_n(reset_n),
      .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wdata(c_wdata),
      .c_gnt(o_c_gnt[1]), .c_rdata(o_c_rdata[1]), .c_rvalid(o_c_rvalid[1]),
      .l_req(l_req), .l_we(l_we), .l_adr(l_adr), .l_wdata(l_wdata),
      .l_gnt(o_l_gnt[1]), .l_rdata(o_l_rdata[1]), .l_rvalid(o_l_rvalid[1]),
      .mem_adr(o_mem_adr[1]), .mem_we(o_mem_we[1]), .mem_wdata(o_mem_wdata[1]),
      .mem_rdata(mem_rdata[1])
   );

   // Combinational memory seen by each DUT.
   assign mem_rdata[0] = env_mem[0][o_mem_adr[0][5:0]];
   assign mem_rdata[1] = env_mem[1][o_mem_adr[1][5:0]];

   task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // owner: 0 nobody, 1 core, 2 loader. last: most recent new owner.
   int          hold_lim [2] = '{4, 0};
   int          owner [2]    = '{0, 0};
   int          last_own [2] = '{2, 2};
   int          run [2]      = '{0, 0};
   bit          m_rv_c [2]   = '{0, 0};
   bit          m_rv_l [2]   = '{0, 0};
   logic [31:0] m_rd_c [2]   = '{0, 0};
   logic [31:0] m_rd_l [2]   = '{0, 0};
   logic [31:0] exp_mem [2][64];

   initial begin
      for (int k = 0; k < 2; k++) begin
         for (int a = 0; a < 64; a++) begin
            logic [31:0] v;
            v = (a == 'h10) ? 32'hDEADBEEF : $urandom;
            env_mem[k][a] <= v;
            exp_mem[k][a] = v;
         end
      end
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
               owner[k] = 0; last_own[k] = 2; run[k] = 0;
               m_rv_c[k] = 0; m_rv_l[k] = 0; m_rd_c[k] = '0; m_rd_l[k] = '0;
            end
         end else begin
            for (int k = 0; k < 2; k++) begin
               bit gc, gl, mine, theirs;
               int nxt, other;
               // Physical memory write driven by the DUT's own bus.
               if (o_mem_we[k]) env_mem[k][o_mem_adr[k][5:0]] <= o_mem_wdata[k];
               // Predicted access for this edge.
               gc = (owner[k] == 1) && c_req;
               gl = (owner[k] == 2) && l_req;
               m_rv_c[k] = gc && !c_we;
               m_rv_l[k] = gl && !l_we;
               if (m_rv_c[k]) m_rd_c[k] = exp_mem[k][c_adr[5:0]];
               if (m_rv_l[k]) m_rd_l[k] = exp_mem[k][l_adr[5:0]];
               if (gc && c_we) exp_mem[k][c_adr[5:0]] = c_wdata;
               if (gl && l_we) exp_mem[k][l_adr[5:0]] = l_wdata;
               if (gc || gl) begin
                  if (k == 0)
                     $display("txn dut%0d %s %s adr=%0h data=%0h", k, gc ? "C" : "L",
                              (gc ? c_we : l_we) ? "wr" : "rd", gc ? c_adr : l_adr,
                              gc ? (c_we ? c_wdata : m_rd_c[k]) : (l_we ? l_wdata : m_rd_l[k]));
               end
               // Ownership rules.
               nxt = owner[k];
               if (owner[k] == 0) begin
                  if (c_req && l_req) nxt = 3 - last_own[k];
                  else if (c_req)     nxt = 1;
                  else if (l_req)     nxt = 2;
               end else begin
                  other  = 3 - owner[k];
                  mine   = (owner[k] == 1) ? c_req : l_req;
                  theirs = (owner[k] == 1) ? l_req : c_req;
                  if (!mine) nxt = theirs ? other : 0;
                  else if (theirs) begin
                     if (hold_lim[k] != 0 && run[k] == hold_lim[k] - 1) nxt = other;
                     else run[k] = run[k] + 1;
                  end
               end
               if (nxt != 0 && nxt != owner[k]) begin
                  last_own[k] = nxt;
                  run[k] = 0;
               end
               owner[k] = nxt;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            bit          egc, egl;
            logic [95:0] ebus;
            egc  = (owner[k] == 1) && c_req;
            egl  = (owner[k] == 2) && l_req;
            ebus = '0;
            if (egc)      ebus = {31'd0, c_adr, c_we, c_wdata};
            else if (egl) ebus = {31'd0, l_adr, l_we, l_wdata};
            check($sformatf("dut%0d_gnt", k), {94'd0, o_c_gnt[k], o_l_gnt[k]}, {94'd0, egc, egl});
            check($sformatf("dut%0d_rvalid", k), {94'd0, o_c_rvalid[k], o_l_rvalid[k]},
                  {94'd0, m_rv_c[k], m_rv_l[k]});
            check($sformatf("dut%0d_c_rdata", k), {64'd0, o_c_rdata[k]}, {64'd0, m_rd_c[k]});
            check($sformatf("dut%0d_l_rdata", k), {64'd0, o_l_rdata[k]}, {64'd0, m_rd_l[k]});
            check($sformatf("dut%0d_membus", k),
                  {31'd0, o_mem_adr[k], o_mem_we[k], o_mem_wdata[k]}, ebus);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_c(input logic req, input logic we, input logic [31:0] adr, input logic [31:0] wd);
      c_req = req; c_we = we; c_adr = adr; c_wdata = wd;
   endtask

   task automatic set_l(input logic req, input logic we, input logic [31:0] adr, input logic [31:0] wd);
      l_req = req; l_we = we; l_adr = adr; l_wdata = wd;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #2 reset_n = 1'b0;
      #2 reset_n = 1'b1;
   endtask

   // Gnt pair for dut k packed as {c,l}.
   function automatic logic [1:0] gnts(input int k);
      return {o_c_gnt[k], o_l_gnt[k]};
   endfunction

   initial begin
      #1 reset_n = 1'b0;
      #2;
      check("reset_outputs",
            {o_c_gnt[0], o_l_gnt[0], o_c_rvalid[0], o_l_rvalid[0], o_mem_we[0], o_mem_adr[0], o_mem_wdata[0]},
            '0);
      check("reset_rdata", {o_c_rdata[0], o_l_rdata[0]}, '0);
      cyc(); cyc(); cyc();
      reset_n = 1'b1;

      // Test 1: single core read, one cycle of arbitration latency.
      cyc(); set_c(1, 0, 32'h10, 0);
      #3 check("t1_cycle1_gnt", gnts(0), 2'b00);
      cyc();
      #3 check("t1_cycle2_gnt", gnts(0), 2'b10);
      cyc(); set_c(0, 0, 0, 0);
      #3 check("t1_rvalid", {o_c_rvalid[0], o_l_rvalid[0], o_l_gnt[0]}, 3'b100);
      check("t1_rdata", o_c_rdata[0], 32'hDEADBEEF);
      cyc();

      // Test 2: tie after reset goes to C, hand-over, then alternating ties.
      pulse_reset();
      cyc(); set_c(1, 0, 32'h3, 0); set_l(1, 0, 32'h4, 0);
      #3 check("t2_idle_gnt", gnts(0), 2'b00);
      cyc();
      #3 check("t2_first_tie", gnts(0), 2'b10);
      cyc(); c_req = 1'b0;
      #3 check("t2_c_dropped", gnts(0), 2'b00);
      cyc();
      #3 check("t2_l_takes_over", gnts(0), 2'b01);
      cyc(); l_req = 1'b0;
      cyc();
      for (int i = 0; i < 4; i++) begin
         set_c(1, 0, $urandom_range(63), 0); set_l(1, 0, $urandom_range(63), 0);
         cyc();
         #3 check($sformatf("t2_tie%0d", i), gnts(0), (i % 2 == 0) ? 2'b10 : 2'b01);
         cyc(); c_req = 1'b0; l_req = 1'b0;
         cyc();
      end

      // Tests 3 and 6: both requesting continuously.
      pulse_reset();
      cyc(); set_c(1, 0, $urandom_range(63), 0); set_l(1, 0, $urandom_range(63), 0);
      for (int i = 0; i < 50; i++) begin
         cyc(); c_adr = $urandom_range(63); l_adr = $urandom_range(63);
         #3 check($sformatf("t3_hold4_%0d", i), gnts(0), ((i / 4) % 2 == 0) ? 2'b10 : 2'b01);
         check($sformatf("t6_unlim_%0d", i), gnts(1), 2'b10);
      end
      cyc(); c_req = 1'b0;
      cyc();
      #3 check("t6_switch_after_drop", gnts(1), 2'b01);
      cyc(); l_req = 1'b0;
      cyc(); cyc();

      // Test 4: loader write, then core read-back.
      pulse_reset();
      cyc(); set_l(1, 1, 32'h20, 32'h12345678);
      cyc();
      #3 check("t4_l_write_gnt", gnts(0), 2'b01);
      cyc(); set_l(0, 0, 0, 0); set_c(1, 0, 32'h20, 0);
      #3 check("t4_no_l_rvalid", o_l_rvalid[0], 1'b0);
      cyc();
      #3 check("t4_c_gnt", gnts(0), 2'b10);
      cyc(); set_c(0, 0, 0, 0);
      #3 check("t4_readback", {o_c_rvalid[0], o_c_rdata[0]}, {1'b1, 32'h12345678});
      cyc();

      // Test 5: asynchronous reset with a loader read in flight.
      pulse_reset();
      cyc(); set_l(1, 0, 32'h10, 0);
      cyc();
      cyc(); l_adr = 32'h11;
      #1 reset_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("t5_async_zero%0d", k),
               {o_c_gnt[k], o_l_gnt[k], o_c_rvalid[k], o_l_rvalid[k], o_mem_we[k],
                o_mem_adr[k], o_mem_wdata[k]}, '0);
         check($sformatf("t5_rdata_zero%0d", k), {o_c_rdata[k], o_l_rdata[k]}, '0);
      end
      #1 reset_n = 1'b1; set_c(1, 0, 32'h12, 0);
      cyc();
      #3 check("t5_after_release", {o_c_gnt[0], o_l_gnt[0], o_l_rvalid[0]}, 3'b100);
      cyc(); set_c(0, 0, 0, 0); set_l(0, 0, 0, 0);
      cyc();

      // Randomised traffic.
      for (int i = 0; i < 500; i++) begin
         cyc();
         set_c($urandom_range(3) != 0, $urandom_range(1), $urandom_range(63), $urandom);
         set_l($urandom_range(3) != 0, $urandom_range(1), $urandom_range(63), $urandom);
      end
      cyc(); set_c(0, 0, 0, 0); set_l(0, 0, 0, 0);
      cyc(); cyc();
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
